stop_watch_time_fmt: RTL and testbench

- Downstream consumer of stop_watch's 32-bit millisecond count (nrms).
- Converts a sampled count into BCD hours:minutes:seconds.milliseconds for the display/driver stage.
- Uses one shared sequential 32-bit restoring divider (1 quotient bit/cycle), run four times per conversion.
- Handshake: start/ready in, one-cycle valid pulse out. Results are held between conversions.

---
 rtl/stop_watch_time_fmt.sv | 157 +++++++++++++++
 tb/tb_stop_watch_time_fmt.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_time_fmt.sv
// Converts a sampled millisecond count into BCD hh:mm:ss.mmm using one shared 32-bit restoring divider run four times.
// Latency: valid pulses in the cycle after acceptance edge E0+129; ready returns one edge after the valid cycle.
// Backpressure: start is honoured only while ready=1, otherwise dropped (optional STOP_WATCH_TIME_FMT_AUTO_SAMPLE_EN adds a periodic internal request).
module stop_watch_time_fmt #(
   parameter int MS_PER_S      = 1000,
   parameter int HR_LIMIT      = 100,
   parameter int SAMPLE_PERIOD = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] nrms,
   input  logic        start,
   output logic        ready,
   output logic        valid,
   output logic [11:0] ms_bcd,
   output logic [7:0]  sec_bcd,
   output logic [7:0]  min_bcd,
   output logic [7:0]  hr_bcd,
   output logic        ovf
);

   typedef enum logic [2:0] {IDLE, D_MS, D_SEC, D_MIN, D_HR, DONE} state_t;

   state_t      state;
   logic [31:0] dvd;      // shifts dividend out / quotient in
   logic [31:0] rem;
   logic [31:0] dsr;
   logic [4:0]  cnt;
   logic [9:0]  ms_bin;
   logic [5:0]  sec_bin;
   logic [5:0]  min_bin;
   logic [6:0]  hr_bin;
   logic        ovf_bin;

   logic [32:0] trial;
   logic        qbit;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic        req;

   function automatic logic [7:0] bcd2(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   function automatic logic [11:0] bcd3(input logic [9:0] v);
      return {4'(v / 10'd100), 4'((v / 10'd10) % 10'd10), 4'(v % 10'd10)};
   endfunction

   // one restoring-division step: shift in next dividend bit, subtract if it fits
   always_comb begin
      trial   = {rem, dvd[31]};
      qbit    = (trial >= {1'b0, dsr});
      rem_nxt = qbit ? 32'(trial - {1'b0, dsr}) : trial[31:0];
      quo_nxt = {dvd[30:0], qbit};
   end

`ifdef STOP_WATCH_TIME_FMT_AUTO_SAMPLE_EN
   localparam int CW = $clog2(SAMPLE_PERIOD);
   logic [CW-1:0] smp_cnt;
   logic          tick;

   assign tick = (smp_cnt == CW'(SAMPLE_PERIOD - 1));
   assign req  = start | tick;

   // free-running sample timer; its request is lost if the converter is busy
   always_ff @(posedge clk) begin
      if (!rst)      smp_cnt <= '0;
      else if (tick) smp_cnt <= '0;
      else           smp_cnt <= smp_cnt + 1'b1;
   end
`else
   assign req = start;
`endif

   // conversion FSM: four 32-cycle divisions, then a single registered BCD update
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         ready   <= 1'b1;
         valid   <= 1'b0;
         ms_bcd  <= '0;
         sec_bcd <= '0;
         min_bcd <= '0;
         hr_bcd  <= '0;
         ovf     <= 1'b0;
         dvd     <= '0;
         rem     <= '0;
         dsr     <= '0;
         cnt     <= '0;
         ms_bin  <= '0;
         sec_bin <= '0;
         min_bin <= '0;
         hr_bin  <= '0;
         ovf_bin <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               // first IDLE cycle only re-arms ready, so a held start sees a one-cycle gap
               if (!ready) begin
                  ready <= 1'b1;
               end else if (req) begin
                  ready <= 1'b0;
                  dvd   <= nrms;
                  rem   <= '0;
                  dsr   <= 32'(MS_PER_S);
                  cnt   <= '0;
                  state <= D_MS;
               end
            end
            D_MS, D_SEC, D_MIN, D_HR: begin
               cnt <= cnt + 5'd1;
               dvd <= quo_nxt;
               rem <= rem_nxt;
               if (cnt == 5'd31) begin
                  // quotient feeds the next division; remainder is this field
                  rem <= '0;
                  case (state)
                     D_MS: begin
                        ms_bin <= rem_nxt[9:0];
                        dsr    <= 32'd60;
                        state  <= D_SEC;
                     end
                     D_SEC: begin
                        sec_bin <= rem_nxt[5:0];
                        dsr     <= 32'd60;
                        state   <= D_MIN;
                     end
                     D_MIN: begin
                        min_bin <= rem_nxt[5:0];
                        dsr     <= 32'(HR_LIMIT);
                        state   <= D_HR;
                     end
                     D_HR: begin
                        hr_bin  <= rem_nxt[6:0];
                        ovf_bin <= (quo_nxt != 32'd0);
                        state   <= DONE;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
            DONE: begin
               ms_bcd  <= bcd3(ms_bin);
               sec_bcd <= bcd2({1'b0, sec_bin});
               min_bcd <= bcd2({1'b0, min_bin});
               hr_bcd  <= bcd2(hr_bin);
               ovf     <= ovf_bin;
               valid   <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stop_watch_time_fmt.sv
module tb_stop_watch_time_fmt;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] nrms = '0;
   logic        ready, valid, ovf;
   logic [11:0] ms_bcd;
   logic [7:0]  sec_bcd, min_bcd, hr_bcd;

   int errors = 0;
   int checks = 0;

   stop_watch_time_fmt dut (
      .clk(clk), .rst(rst), .nrms(nrms), .start(start),
      .ready(ready), .valid(valid), .ms_bcd(ms_bcd), .sec_bcd(sec_bcd),
      .min_bcd(min_bcd), .hr_bcd(hr_bcd), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] n;
      logic [7:0]  hr;
      logic [7:0]  mn;
      logic [7:0]  sc;
      logic [11:0] ms;
      logic        ov;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // reference: plain time arithmetic on the millisecond count
   function automatic logic [36:0] model(input logic [31:0] n);
      longint t, h, hm, m, s, ms;
      t  = longint'(n);
      ms = t % 1000;
      s  = (t / 1000) % 60;
      m  = (t / 60000) % 60;
      h  = t / 3600000;
      hm = h % 100;
      return {(h >= 100),
              4'(hm / 10), 4'(hm % 10),
              4'(m / 10),  4'(m % 10),
              4'(s / 10),  4'(s % 10),
              4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
   endfunction

   function automatic logic [36:0] outs();
      return {ovf, hr_bcd, min_bcd, sec_bcd, ms_bcd};
   endfunction

   // pulse start with n, expect valid exactly at edge E0+129, then a one-cycle pulse and ready back
   task automatic run_conv(input logic [31:0] n, input string tag);
      int  cyc;
      bit  got;
      @(negedge clk);
      nrms  = n;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      got = 0;
      while (cyc < 300 && !got) begin
         @(posedge clk);
         cyc++;
         #1;
         if (valid) got = 1;
      end
      chk({tag, "_latency"}, cyc, 129);
      chk({tag, "_ready_in_valid"}, ready, 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_valid_width"}, valid, 1'b0);
      chk({tag, "_ready_back"}, ready, 1'b1);
   endtask

   initial begin
      logic [36:0] prev;
      logic [31:0] a, b, r;
      int          vcount, lat, partial_bad, late_valid;

      vecs[0] = '{32'd3723004,   8'h01, 8'h02, 8'h03, 12'h004, 1'b0};
      vecs[1] = '{32'd359999999, 8'h99, 8'h59, 8'h59, 12'h999, 1'b0};
      vecs[2] = '{32'd360000000, 8'h00, 8'h00, 8'h00, 12'h000, 1'b1};
      vecs[3] = '{32'hFFFFFFFF,  8'h93, 8'h02, 8'h47, 12'h295, 1'b1};
      vecs[4] = '{32'd0,         8'h00, 8'h00, 8'h00, 12'h000, 1'b0};

      // reset held with start asserted
      rst   = 1'b0;
      start = 1'b1;
      nrms  = 32'd12345;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 1'b1);
      chk("rst_valid", valid, 1'b0);
      chk("rst_outs", outs(), 37'd0);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_conv_ready", ready, 1'b1);
      chk("rst_no_conv_valid", valid, 1'b0);

      // table of directed values
      for (int i = 0; i < 5; i++) begin
         run_conv(vecs[i].n, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_hr", i),  hr_bcd,  vecs[i].hr);
         chk($sformatf("vec%0d_min", i), min_bcd, vecs[i].mn);
         chk($sformatf("vec%0d_sec", i), sec_bcd, vecs[i].sc);
         chk($sformatf("vec%0d_ms", i),  ms_bcd,  vecs[i].ms);
         chk($sformatf("vec%0d_ovf", i), ovf,     vecs[i].ov);
      end

      // randomized values against the reference
      for (int i = 0; i < 20; i++) begin
         r = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 400000000));
         run_conv(r, $sformatf("rnd%0d", i));
         chk($sformatf("rnd%0d_outs n=%0d", i, r), outs(), model(r));
      end

      // start re-pulse and nrms change during a running conversion are ignored
      run_conv(32'd3723004, "pre");
      prev = outs();
      a = 32'd123456789;
      b = 32'd987654;
      @(negedge clk);
      nrms  = a;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      vcount = 0;
      lat = 0;
      partial_bad = 0;
      for (int k = 1; k <= 280; k++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            vcount++;
            if (lat == 0) lat = k;
         end else if (lat == 0 && outs() != prev) begin
            partial_bad++;
         end
         start = (k == 49);
         if (k == 9) nrms = b;
      end
      start = 1'b0;
      chk("ign_valid_count", vcount, 1);
      chk("ign_latency", lat, 129);
      chk("ign_no_partial", partial_bad, 0);
      chk("ign_outs", outs(), model(a));

      // reset in the middle of a conversion aborts it
      @(negedge clk);
      nrms  = 32'd55555555;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      late_valid = 0;
      for (int k = 1; k <= 69; k++) begin
         @(posedge clk);
         #1;
         if (valid) late_valid++;
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("abort_ready", ready, 1'b1);
      chk("abort_valid", valid, 1'b0);
      chk("abort_outs", outs(), 37'd0);
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (valid) late_valid++;
      end
      chk("abort_no_valid", late_valid, 0);
      run_conv(32'd3723004, "fresh");
      chk("fresh_outs", outs(), model(32'd3723004));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
